// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder with valid/ready handshaking on both sides.
// Optional signed-overflow output o_ovf is built only when CSA_OVF_EN is defined.
module csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CSA_OVF_EN
    output logic             o_ovf,
`endif
    output logic             cout
);

    localparam int NB = WIDTH / BLOCK;

    // Per-slice speculative ripple results for carry-in 0 and carry-in 1.
    logic [NB-1:0][BLOCK-1:0] rip_sum0;
    logic [NB-1:0][BLOCK-1:0] rip_sum1;
    logic [NB-1:0]            rip_c0;
    logic [NB-1:0]            rip_c1;

    // Stage 1 state.
    logic                     s1_valid_q, s1_valid_d;
    logic [NB-1:0][BLOCK-1:0] s1_sum0_q, s1_sum0_d;
    logic [NB-1:0][BLOCK-1:0] s1_sum1_q, s1_sum1_d;
    logic [NB-1:0]            s1_c0_q, s1_c0_d;
    logic [NB-1:0]            s1_c1_q, s1_c1_d;

    // Stage 2 state.
    logic                     s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]         sum_q, sum_d;
    logic                     cout_q, cout_d;

    // Handshake and carry-resolution nets.
    logic                     s2_adv;
    logic                     s1_adv;
    logic [WIDTH-1:0]         sel_sum;
    logic                     sel_c;

    // Slice 0 sees the real carry-in on both paths, so either selection is correct.
    for (genvar k = 0; k < NB; k++) begin : g_slice
        logic             cin_lo;
        logic             cin_hi;
        logic [BLOCK:0]   t0;
        logic [BLOCK:0]   t1;

        if (k == 0) begin : g_lsb
            assign cin_lo = i_cin;
            assign cin_hi = i_cin;
        end else begin : g_upper
            assign cin_lo = 1'b0;
            assign cin_hi = 1'b1;
        end

        assign t0 = {1'b0, i_add_term1[k*BLOCK +: BLOCK]}
                  + {1'b0, i_add_term2[k*BLOCK +: BLOCK]}
                  + {{BLOCK{1'b0}}, cin_lo};
        assign t1 = {1'b0, i_add_term1[k*BLOCK +: BLOCK]}
                  + {1'b0, i_add_term2[k*BLOCK +: BLOCK]}
                  + {{BLOCK{1'b0}}, cin_hi};

        assign rip_sum0[k] = t0[BLOCK-1:0];
        assign rip_c0[k]   = t0[BLOCK];
        assign rip_sum1[k] = t1[BLOCK-1:0];
        assign rip_c1[k]   = t1[BLOCK];
    end

    // A stage advances when it is empty or its occupant leaves this cycle.
    assign s2_adv  = !s2_valid_q || i_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign o_ready = s1_adv;

    // Walk the block carry chain, picking each slice's pair by the previous selected carry.
    always_comb begin
        sel_sum = '0;
        sel_c   = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (sel_c) begin
                sel_sum[k*BLOCK +: BLOCK] = s1_sum1_q[k];
                sel_c                     = s1_c1_q[k];
            end else begin
                sel_sum[k*BLOCK +: BLOCK] = s1_sum0_q[k];
                sel_c                     = s1_c0_q[k];
            end
        end
    end

    // Stage 1 next state: capture speculative slice results on acceptance.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum0_d  = s1_sum0_q;
        s1_sum1_d  = s1_sum1_q;
        s1_c0_d    = s1_c0_q;
        s1_c1_d    = s1_c1_q;
        if (s1_adv) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_sum0_d = rip_sum0;
                s1_sum1_d = rip_sum1;
                s1_c0_d   = rip_c0;
                s1_c1_d   = rip_c1;
            end else begin
                s1_sum0_d = s1_sum0_q;
                s1_sum1_d = s1_sum1_q;
                s1_c0_d   = s1_c0_q;
                s1_c1_d   = s1_c1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: data only loads when a valid stage-1 entry moves in.
    always_comb begin
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = sel_sum;
                cout_d = sel_c;
            end else begin
                sum_d  = sum_q;
                cout_d = cout_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset empties both stages and zeroes the visible result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sum0_q  <= '0;
            s1_sum1_q  <= '0;
            s1_c0_q    <= '0;
            s1_c1_q    <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum0_q  <= s1_sum0_d;
            s1_sum1_q  <= s1_sum1_d;
            s1_c0_q    <= s1_c0_d;
            s1_c1_q    <= s1_c1_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
        end
    end

    assign o_valid = s2_valid_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

`ifdef CSA_OVF_EN
    logic s1_amsb_q, s1_amsb_d;
    logic s1_bmsb_q, s1_bmsb_d;
    logic ovf_q, ovf_d;

    // Operand sign bits travel with stage 1 so overflow can be judged against the final sum.
    always_comb begin
        s1_amsb_d = s1_amsb_q;
        s1_bmsb_d = s1_bmsb_q;
        if (s1_adv && i_valid) begin
            s1_amsb_d = i_add_term1[WIDTH-1];
            s1_bmsb_d = i_add_term2[WIDTH-1];
        end else begin
            s1_amsb_d = s1_amsb_q;
            s1_bmsb_d = s1_bmsb_q;
        end
    end

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    always_comb begin
        ovf_d = ovf_q;
        if (s2_adv && s1_valid_q) begin
            ovf_d = (s1_amsb_q == s1_bmsb_q) && (sel_sum[WIDTH-1] != s1_amsb_q);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow registers share the pipeline's reset behaviour.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_amsb_q <= 1'b0;
            s1_bmsb_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1_amsb_q <= s1_amsb_d;
            s1_bmsb_q <= s1_bmsb_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder (WIDTH=16, BLOCK=4): directed vector table,
// random back-to-back stream, backpressure stall and asynchronous reset sequences.
module tb_csa_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        in_ready;
    logic [15:0] sum_w;
    logic        cout_w;
`ifdef CSA_OVF_EN
    logic        ovf_w;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_add_term1 (a),
        .i_add_term2 (b),
        .i_cin       (cin),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .sum         (sum_w),
`ifdef CSA_OVF_EN
        .o_ovf       (ovf_w),
`endif
        .cout        (cout_w)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t tv[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        in_ready = 1'b1;
        #1 check("vec_ready", 32'(out_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("vec_latency1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 check("vec_valid", 32'(out_valid), 32'd1);
        check("vec_sum", 32'(sum_w), 32'(v.s));
        check("vec_cout", 32'(cout_w), 32'(v.co));
`ifdef CSA_OVF_EN
        check("vec_ovf", 32'(ovf_w), 32'(v.ovf));
`endif
    endtask

    // Stream n random operands; optional i_ready stall window [st0, st0+stlen).
    task automatic run_stream(input int n, input int st0, input int stlen, input string tag);
        logic [18:0] q[$];
        logic [18:0] e;
        logic [15:0] na;
        logic [15:0] nb;
        logic        nc;
        logic        stalled;
        logic        acc;
        logic        xfer;
        int          sent;
        int          got;
        int          cyc;
        int          stall_acc;
        @(negedge clk);
        in_valid = 1'b0;
        in_ready = 1'b1;
        repeat (3) @(posedge clk);
        sent = 0; got = 0; cyc = 0; stall_acc = 0;
        na = 16'($urandom()); nb = 16'($urandom()); nc = 1'($urandom());
        while ((sent < n || got < n) && cyc < 4 * n + 50) begin
            @(negedge clk);
            stalled  = (stlen > 0) && (cyc >= st0) && (cyc < st0 + stlen);
            in_ready = !stalled;
            in_valid = (sent < n);
            a = na; b = nb; cin = nc;
            #1;
            acc  = in_valid && out_ready;
            xfer = out_valid && in_ready;
            if (stalled && cyc >= st0 + 2) begin
                check({tag, "_stall_ready"}, 32'(out_ready), 32'd0);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, 32'(sum_w), 32'hFFFF_FFFF);
                end else begin
                    e = q[0];
                    check({tag, "_sum"}, 32'(sum_w), 32'(e[15:0]));
                    check({tag, "_cout"}, 32'(cout_w), 32'(e[16]));
`ifdef CSA_OVF_EN
                    check({tag, "_ovf"}, 32'(ovf_w),
                          32'((e[18] == e[17]) && (e[15] != e[18])));
`endif
                    if (xfer) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            @(posedge clk);
            if (acc) begin
                e[16:0] = {1'b0, na} + {1'b0, nb} + {16'd0, nc};
                e[18]   = na[15];
                e[17]   = nb[15];
                q.push_back(e);
                sent++;
                if (stalled) stall_acc++;
                na = 16'($urandom()); nb = 16'($urandom()); nc = 1'($urandom());
            end
            cyc++;
        end
        check({tag, "_sent"}, 32'(sent), 32'(n));
        check({tag, "_got"}, 32'(got), 32'(n));
        if (stlen > 0) begin
            check({tag, "_stall_accepts"}, 32'(stall_acc), 32'd2);
        end else begin
            check({tag, "_cycles"}, 32'(cyc), 32'(n + 2));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[1]  = '{16'h0FFF, 16'hF000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[4]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tv[5]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tv[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tv[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[8]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tv[9]  = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[10] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        tv[11] = '{16'hFFF0, 16'h000F, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
        a = 16'h0000; b = 16'h0000; cin = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum_w), 32'd0);
        check("rst_cout", 32'(cout_w), 32'd0);
`ifdef CSA_OVF_EN
        check("rst_ovf", 32'(ovf_w), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_ready", 32'(out_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            apply_vec(tv[i]);
        end

        run_stream(200, 0, 0, "rand");
        run_stream(10, 0, 5, "bp");

        // Fill both stages under stall, then reset asynchronously mid-cycle.
        @(negedge clk);
        in_ready = 1'b0; in_valid = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'h3333; b = 16'h4444; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("full_valid", 32'(out_valid), 32'd1);
        check("full_ready", 32'(out_ready), 32'd0);
        check("full_sum", 32'(sum_w), 32'h3333);
        #2 rst = 1'b1;
        #1 check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_sum", 32'(sum_w), 32'd0);
        check("arst_cout", 32'(cout_w), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_ready = 1'b1;
        #1 check("arst_ready", 32'(out_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("arst_no_old", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_pipe_adder.md
CSA_PIPE_ADDER -- requirements
Module: csa_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 The block SHALL have parameter BLOCK, default 4, carry-select block width in bits.
- Legal values: WIDTH a multiple of BLOCK; BLOCK >= 2; WIDTH/BLOCK >= 2.
REQ-003 The block SHALL have port i_clk, input, 1, sole clock; all registers rise-edge.
REQ-004 The block SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port i_valid, input, 1, operands present.
REQ-006 The block SHALL have port o_ready, output, 1, block accepts operands this cycle.
REQ-007 The block SHALL have port i_add_term1, input, WIDTH, operand A.
REQ-008 The block SHALL have port i_add_term2, input, WIDTH, operand B.
REQ-009 The block SHALL have port i_cin, input, 1, carry-in.
REQ-010 The block SHALL have port o_valid, output, 1, result present.
REQ-011 The block SHALL have port i_ready, input, 1, downstream accepts result.
REQ-012 The block SHALL have port sum, output, WIDTH, result bits.
REQ-013 The block SHALL have port cout, output, 1, carry-out of MSB.
REQ-014 The block SHALL have port o_ovf, output, 1, signed overflow; present only under CSA_OVF_EN.

Function
REQ-015 The block SHALL compute {cout,sum} = i_add_term1 + i_add_term2 + i_cin, modulo 2^(WIDTH+1).
REQ-016 Stage 1 SHALL register, per BLOCK slice, the ripple sum and carry for block carry-in 0 and for carry-in 1; slice 0 SHALL use i_cin directly.
REQ-017 Stage 2 SHALL resolve the block carry chain by selecting, per slice, the sum/carry pair indexed by the previous slice's selected carry, and SHALL register sum, cout (and o_ovf).
REQ-018 Latency SHALL be exactly 2 cycles from acceptance (i_valid && o_ready) to o_valid with no backpressure.
REQ-019 Throughput SHALL be one result per cycle while i_ready stays high.
REQ-020 Each stage SHALL hold a valid flag; a stage SHALL load when it is empty or its contents are leaving the same cycle.
REQ-021 o_ready SHALL equal !s1_valid || (!s2_valid || i_ready); it SHALL be combinational from i_ready.
REQ-022 o_valid SHALL equal the stage-2 valid flag; sum/cout SHALL be stable while o_valid && !i_ready.
REQ-023 With both stages full and i_ready low, o_ready SHALL be 0 and no data SHALL be lost, duplicated or reordered.
REQ-024 When a result leaves (o_valid && i_ready) and a new operand is accepted in the same cycle, both transfers SHALL occur.
REQ-025 Data registers of an empty stage SHALL not load; an invalid stage's contents are don't-care except as covered by REQ-027.

Reset
REQ-026 i_rst high SHALL clear both stage valid flags immediately, independent of i_clk.
REQ-027 During and after reset: o_valid=0, sum=0, cout=0, o_ovf=0, o_ready=1 once i_rst is low.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear at the output.

Configuration
REQ-029 Macro CSA_OVF_EN defined: o_ovf SHALL exist, registered with sum, = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
REQ-030 Macro CSA_OVF_EN undefined: port o_ovf and its logic SHALL be absent; all other behaviour unchanged.

Verification (WIDTH=16, BLOCK=4)
REQ-031 0xFFFF + 0x0001, cin=0, i_ready=1 -> two cycles later o_valid=1, sum=0x0000, cout=1.
REQ-032 0x0FFF + 0xF000, cin=1 -> sum=0x0000, cout=1 (carry selected through all 4 slices).
REQ-033 CSA_OVF_EN defined, 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, o_ovf=1; 0xFFFF + 0x0001 -> o_ovf=0.
REQ-034 200 random operands back-to-back, i_ready=1 -> one result per cycle, in order, all match A+B+cin.
REQ-035 Feed continuously, i_ready low 5 cycles -> o_ready low after 2 accepted, outputs held; on release no loss/duplication.
REQ-036 Assert i_rst asynchronously with both stages full -> o_valid=0, sum=0 at once; no old result after release.
